// File: rtl/rename_stage_pkg.sv
// Shared types and constants for the register-rename stage.
// Opcode encodings follow the RV32I base major opcodes.
package rename_stage_pkg;

  localparam int ARCH_REGS   = 32;
  localparam int PHYS_REGS   = 64;
  localparam int PREG_W      = 6;
  localparam int FL_DEPTH    = PHYS_REGS - ARCH_REGS;
  localparam int FL_PTR_W    = 5;
  localparam int FL_CNT_W    = 6;
  localparam int AREG_W      = 5;
  localparam int PC_W        = 12;
  localparam int C_SIG_WIDTH = 7;
  localparam int ALU_W       = 3;

  typedef enum logic [6:0] {
    OP_RTYPE = 7'b0110011,
    OP_ITYPE = 7'b0010011,
    OP_LOAD  = 7'b0000011,
    OP_LUI   = 7'b0110111,
    OP_STORE = 7'b0100011
  } opcode_e;

  typedef struct packed {
    logic                   valid;
    logic [PC_W-1:0]        pc;
    logic [C_SIG_WIDTH-1:0] c_sig;
    logic [ALU_W-1:0]       alu_sig;
    logic [31:0]            imm;
    logic [PREG_W-1:0]      prs1;
    logic [PREG_W-1:0]      prs2;
    logic [PREG_W-1:0]      prd;
    logic [PREG_W-1:0]      old_prd;
    logic                   has_rd;
  } rename_pkt_t;

  // Only these opcodes produce a register result; x0 is never renamed.
  function automatic logic writes_rd(input logic [6:0] opcode, input logic [AREG_W-1:0] rd);
    logic result;
    result = 1'b0;
    case (opcode)
      OP_RTYPE, OP_ITYPE, OP_LOAD, OP_LUI: result = (rd != '0);
      default:                             result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/rename_stage_free_list.sv
// Circular FIFO of free physical tags, preloaded with p32..p63 at reset.
// With RENAME_TRACE_EN defined, dropped and duplicate retires are reported.
module rename_stage_free_list
  import rename_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                pop,
  input  logic                push,
  input  logic [PREG_W-1:0]   push_tag,
  output logic [PREG_W-1:0]   head_tag,
  output logic [FL_CNT_W-1:0] count
);

  logic [PREG_W-1:0]   mem [FL_DEPTH];
  logic [FL_PTR_W-1:0] head;
  logic [FL_PTR_W-1:0] tail;
  logic                push_ok;
  logic                pop_ok;

  // A push into a full list is dropped; the pop side is never asked to underflow.
  assign push_ok  = push && (count != FL_CNT_W'(FL_DEPTH));
  assign pop_ok   = pop && (count != '0);
  assign head_tag = mem[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= FL_CNT_W'(FL_DEPTH);
      for (int i = 0; i < FL_DEPTH; i++) begin
        mem[i] <= PREG_W'(ARCH_REGS + i);
      end
    end else begin
      if (pop_ok) begin
        head <= head + 1'b1;
      end
      if (push_ok) begin
        mem[tail] <= push_tag;
        tail      <= tail + 1'b1;
      end
      count <= count + FL_CNT_W'(push_ok) - FL_CNT_W'(pop_ok);
    end
  end

`ifdef RENAME_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      if (!push_ok) begin
        $display("[rename] retire p%0d dropped: free list full", push_tag);
      end
      for (int i = 0; i < FL_DEPTH; i++) begin
        if (({1'b0, FL_PTR_W'(i) - head} < count) && (mem[i] == push_tag)) begin
          $display("[rename] retire p%0d already present in free list", push_tag);
        end
      end
    end
  end
`endif

endmodule

// File: rtl/rename_stage.sv
// Register-rename stage: RAT lookup, free-list allocation and registered output packet.
// Define RENAME_TRACE_EN to print a trace line per accepted instruction and per bad retire.
module rename_stage
  import rename_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            instr_in,
  input  logic [PC_W-1:0]        pc_in,
  input  logic [C_SIG_WIDTH-1:0] c_sig_in,
  input  logic [ALU_W-1:0]       alu_sig_in,
  input  logic [31:0]            imm_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
  output logic [C_SIG_WIDTH-1:0] out_c_sig,
  output logic [ALU_W-1:0]       out_alu_sig,
  output logic [31:0]            out_imm,
  output logic [PREG_W-1:0]      out_prs1,
  output logic [PREG_W-1:0]      out_prs2,
  output logic [PREG_W-1:0]      out_prd,
  output logic [PREG_W-1:0]      out_old_prd,
  output logic                   out_has_rd,
  input  logic                   retire_valid,
  input  logic [PREG_W-1:0]      retire_preg
);

  logic [PREG_W-1:0]   rat [ARCH_REGS];
  logic [AREG_W-1:0]   rd;
  logic [AREG_W-1:0]   rs1;
  logic [AREG_W-1:0]   rs2;
  logic [6:0]          opcode;
  logic                dec_writes_rd;
  logic                accept;
  logic                fl_pop;
  logic                fl_push;
  logic [PREG_W-1:0]   fl_head_tag;
  logic [FL_CNT_W-1:0] fl_count;
  rename_pkt_t         pkt_d;
  rename_pkt_t         pkt_q;
  logic                unused_instr_bits;

  assign opcode            = instr_in[6:0];
  assign rd                = instr_in[11:7];
  assign rs1               = instr_in[19:15];
  assign rs2               = instr_in[24:20];
  assign unused_instr_bits = ^{instr_in[31:25], instr_in[14:12]};
  assign dec_writes_rd     = writes_rd(opcode, rd);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // Upstream is ready when the output slot is empty or draining this cycle and,
  // for instructions that need a destination, a free tag exists. A presented
  // output packet stays unchanged until out_ready takes it.
  assign in_ready = (!pkt_q.valid || out_ready) && (!dec_writes_rd || (fl_count != '0));
  assign accept   = in_valid && in_ready;
  assign fl_pop   = accept && dec_writes_rd;
  assign fl_push  = retire_valid && (retire_preg != '0);

  rename_stage_free_list u_free_list (
    .clk      (clk),
    .rst      (rst),
    .pop      (fl_pop),
    .push     (fl_push),
    .push_tag (retire_preg),
    .head_tag (fl_head_tag),
    .count    (fl_count)
  );

  // Sources come from the pre-edge RAT, so a back-to-back consumer sees the
  // producer's mapping because the RAT was written at the producer's accept edge.
  always_comb begin
    pkt_d         = '0;
    pkt_d.valid   = 1'b1;
    pkt_d.pc      = pc_in;
    pkt_d.c_sig   = c_sig_in;
    pkt_d.alu_sig = alu_sig_in;
    pkt_d.imm     = imm_in;
    pkt_d.prs1    = (rs1 == '0) ? '0 : rat[rs1];
    pkt_d.prs2    = (rs2 == '0) ? '0 : rat[rs2];
    pkt_d.has_rd  = dec_writes_rd;
    if (dec_writes_rd) begin
      pkt_d.prd     = fl_head_tag;
      pkt_d.old_prd = rat[rd];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_q <= '0;
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat[i] <= PREG_W'(i);
      end
    end else begin
      if (accept) begin
        pkt_q <= pkt_d;
        if (dec_writes_rd) begin
          rat[rd] <= fl_head_tag;
        end
      end else if (out_ready) begin
        pkt_q.valid <= 1'b0;
      end
    end
  end

  assign out_valid   = pkt_q.valid;
  assign out_pc      = pkt_q.pc;
  assign out_c_sig   = pkt_q.c_sig;
  assign out_alu_sig = pkt_q.alu_sig;
  assign out_imm     = pkt_q.imm;
  assign out_prs1    = pkt_q.prs1;
  assign out_prs2    = pkt_q.prs2;
  assign out_prd     = pkt_q.prd;
  assign out_old_prd = pkt_q.old_prd;
  assign out_has_rd  = pkt_q.has_rd;

`ifdef RENAME_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      $display("[rename] pc=%03h x%0d->p%0d old=p%0d prs1=p%0d prs2=p%0d",
               pc_in, rd, pkt_d.prd, pkt_d.old_prd, pkt_d.prs1, pkt_d.prs2);
    end
  end
`endif

endmodule

// File: tb/tb_rename_stage.sv
// Scoreboard bench for rename_stage: directed vectors push expected packets,
// a negedge monitor pops and compares every output handshake.
module tb_rename_stage;

  localparam int PKT_W = 12 + 7 + 3 + 32 + 6 * 4 + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr_in = '0;
  logic [11:0] pc_in = '0;
  logic [6:0]  c_sig_in = '0;
  logic [2:0]  alu_sig_in = '0;
  logic [31:0] imm_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] out_pc;
  logic [6:0]  out_c_sig;
  logic [2:0]  out_alu_sig;
  logic [31:0] out_imm;
  logic [5:0]  out_prs1;
  logic [5:0]  out_prs2;
  logic [5:0]  out_prd;
  logic [5:0]  out_old_prd;
  logic        out_has_rd;
  logic        retire_valid = 1'b0;
  logic [5:0]  retire_preg = '0;

  logic [PKT_W-1:0] exp_q[$];
  logic [PKT_W-1:0] mon_exp;
  int checks = 0;
  int failures = 0;

  rename_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr_in(instr_in), .pc_in(pc_in), .c_sig_in(c_sig_in),
    .alu_sig_in(alu_sig_in), .imm_in(imm_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_c_sig(out_c_sig),
    .out_alu_sig(out_alu_sig), .out_imm(out_imm), .out_prs1(out_prs1),
    .out_prs2(out_prs2), .out_prd(out_prd), .out_old_prd(out_old_prd),
    .out_has_rd(out_has_rd), .retire_valid(retire_valid), .retire_preg(retire_preg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- encoders and passthrough field generators ----------------
  function automatic logic [31:0] r_type(input int rd, input int rs1, input int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] i_type(input int rd, input int rs1, input int imm);
    return {12'(imm), 5'(rs1), 3'd0, 5'(rd), 7'b0010011};
  endfunction
  function automatic logic [31:0] s_type(input int rs1, input int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'd0, 7'b0100011};
  endfunction
  function automatic logic [6:0]  c_of(input logic [11:0] pc); return pc[6:0] ^ 7'h2a; endfunction
  function automatic logic [2:0]  a_of(input logic [11:0] pc); return pc[4:2]; endfunction
  function automatic logic [31:0] i_of(input logic [11:0] pc); return {20'hA5A5C, pc}; endfunction

  function automatic logic [PKT_W-1:0] mk_exp(input logic [11:0] pc, input int p1, input int p2,
                                              input int prd, input int old, input bit has);
    return {pc, c_of(pc), a_of(pc), i_of(pc), 6'(p1), 6'(p2), 6'(prd), 6'(old), has};
  endfunction

  function automatic logic [PKT_W-1:0] pack_out();
    return {out_pc, out_c_sig, out_alu_sig, out_imm, out_prs1, out_prs2,
            out_prd, out_old_prd, out_has_rd};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- driver tasks (entered and left #1 after a posedge) ----------------
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    retire_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drive_in(input logic [31:0] instr, input logic [11:0] pc);
    in_valid   = 1'b1;
    instr_in   = instr;
    pc_in      = pc;
    c_sig_in   = c_of(pc);
    alu_sig_in = a_of(pc);
    imm_in     = i_of(pc);
  endtask

  task automatic issue(input logic [31:0] instr, input logic [11:0] pc, input int p1, input int p2,
                       input int prd, input int old, input bit has, input bit expect_out);
    int cyc;
    drive_in(instr, pc);
    cyc = 0;
    @(negedge clk);
    while (!in_ready && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    chk("accept_wait", in_ready, 1'b1);
    if (in_ready && expect_out) exp_q.push_back(mk_exp(pc, p1, p2, prd, old, has));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out actual=%0h required=none", pack_out());
      end else begin
        mon_exp = exp_q.pop_front();
        chk("out_pkt", pack_out(), mon_exp);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_fields", {out_pc, out_imm, out_prd, out_old_prd, out_prs1, out_has_rd}, '0);
    @(posedge clk);
    #1;

    // Basic rename, back-to-back dependence, non-writers, free count unchanged
    issue(r_type(3, 1, 2), 12'h010, 1, 2, 32, 3, 1'b1, 1'b1);
    issue(r_type(4, 3, 3), 12'h014, 32, 32, 33, 4, 1'b1, 1'b1);
    issue(s_type(5, 3), 12'h018, 5, 32, 0, 0, 1'b0, 1'b1);
    issue(i_type(0, 1, 1), 12'h01c, 1, 1, 0, 0, 1'b0, 1'b1);
    issue(r_type(6, 1, 2), 12'h020, 1, 2, 34, 6, 1'b1, 1'b1);
    drain();

    // Exhaust the free list, then recover through a retire
    do_reset();
    for (int i = 0; i < 32; i++) begin
      issue(i_type((i < 31) ? i + 1 : 1, 0, 0), 12'h300 + 12'(i), 0, 0, 32 + i,
            (i < 31) ? i + 1 : 32, 1'b1, 1'b1);
    end
    drive_in(i_type(2, 0, 0), 12'h3ff);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("fl_empty_stall", in_ready, 1'b0);
    end
    @(posedge clk);
    #1 retire_valid = 1'b1;
    retire_preg = 6'd0;
    @(posedge clk);
    #1 retire_preg = 6'd3;
    @(negedge clk);
    chk("zero_retire_and_no_bypass", in_ready, 1'b0);
    @(posedge clk);
    #1 retire_valid = 1'b0;
    @(negedge clk);
    chk("retire_frees", in_ready, 1'b1);
    exp_q.push_back(mk_exp(12'h3ff, 0, 0, 3, 33, 1'b1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();

    // Output back-pressure holds the packet and freezes rename state
    do_reset();
    out_ready = 1'b0;
    issue(r_type(3, 1, 2), 12'h100, 1, 2, 32, 3, 1'b1, 1'b1);
    drive_in(r_type(4, 3, 3), 12'h104);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_hold", {out_valid, out_pc, out_prs1, out_prs2, out_prd, out_old_prd},
          {1'b1, 12'h100, 6'd1, 6'd2, 6'd32, 6'd3});
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    issue(r_type(4, 3, 3), 12'h104, 32, 32, 33, 4, 1'b1, 1'b1);
    drain();

    // Reset while a packet is in flight
    out_ready = 1'b0;
    issue(r_type(7, 1, 2), 12'h200, 1, 2, 34, 7, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    issue(r_type(3, 1, 2), 12'h204, 1, 2, 32, 3, 1'b1, 1'b1);
    drain();

    chk("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
